// File: rtl/iomem_initiator.sv
// iomem_initiator: single-outstanding iomem bus master with command/response ports and timeout
module iomem_initiator #(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter logic [31:0] ERR_RDATA = 32'hDEADBEEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [3:0]  cmd_wstrb,
  input  logic [31:0] cmd_addr,
  input  logic [31:0] cmd_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic [7:0]  err_count,
  output logic        iomem_valid,
  input  logic        iomem_ready,
  output logic [3:0]  iomem_wstrb,
  output logic [31:0] iomem_addr,
  output logic [31:0] iomem_wdata,
  input  logic [31:0] iomem_rdata
);
  typedef enum logic [1:0] {IDLE, BUS, RESP} state_t;
  state_t state, state_n;
  logic [31:0] cnt;
  logic tmo;
  assign tmo = (TIMEOUT_CYCLES != 0) && (cnt == TIMEOUT_CYCLES - 1);
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = cmd_valid && cmd_ready ? BUS : IDLE;
      BUS:     state_n = iomem_ready || tmo ? RESP : BUS;
      RESP:    state_n = rsp_ready ? IDLE : RESP;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk) state <= reset ? IDLE : state_n;
  // ready beats timeout on the same edge: the iomem_ready branch is checked first
  always_ff @(posedge clk) begin
    if (reset) begin
      cmd_ready   <= 1'b1;
      iomem_valid <= 1'b0;
      iomem_wstrb <= '0;
      iomem_addr  <= '0;
      iomem_wdata <= '0;
      rsp_valid   <= 1'b0;
      rsp_err     <= 1'b0;
      rsp_rdata   <= '0;
      err_count   <= '0;
      cnt         <= '0;
    end else begin
      if (state == IDLE && state_n == BUS) begin
        iomem_valid <= 1'b1;
        iomem_wstrb <= cmd_wstrb;
        iomem_addr  <= cmd_addr;
        iomem_wdata <= cmd_wdata;
        cmd_ready   <= 1'b0;
        cnt         <= '0;
      end
      if (state == BUS) begin
        cnt <= cnt + 1;
        if (iomem_ready) begin
          iomem_valid <= 1'b0;
          rsp_rdata   <= iomem_wstrb == 4'd0 ? iomem_rdata : 32'd0;
          rsp_err     <= 1'b0;
          rsp_valid   <= 1'b1;
        end else if (tmo) begin
          iomem_valid <= 1'b0;
          rsp_rdata   <= ERR_RDATA;
          rsp_err     <= 1'b1;
          rsp_valid   <= 1'b1;
          err_count   <= err_count + {7'd0, err_count != 8'hFF};
        end
      end
      if (state == RESP && rsp_ready) begin
        rsp_valid <= 1'b0;
        cmd_ready <= 1'b1;
      end
    end
  end
endmodule

// File: doc/iomem_initiator.md
Name: iomem_initiator

Overview:
- Bus-master engine for the iomem peripheral bus: the initiating end of the valid/ready handshake that iomem responders such as the GPIO register implement.
- Accepts one read or write command at a time on a simple command port and drives a single iomem transaction.
- Returns read data or a timeout error on a response port.
- Used by debug/DMA-style agents that must access iomem peripherals without the CPU.

Parameters:
- TIMEOUT_CYCLES, 255: max cycles iomem_valid stays high awaiting iomem_ready; 0 disables the timeout.
- ERR_RDATA, 32'hDEADBEEF: rsp_rdata value returned on timeout.

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous active-high reset
- cmd_valid  input  1  command request
- cmd_ready  output  1  command accepted when cmd_valid && cmd_ready
- cmd_wstrb  input  4  byte write strobes; 0 = read
- cmd_addr  input  32  target address
- cmd_wdata  input  32  write data
- rsp_valid  output  1  response available
- rsp_ready  input  1  response consumed when rsp_valid && rsp_ready
- rsp_rdata  output  32  read data (ERR_RDATA on timeout)
- rsp_err  output  1  1 = transaction timed out
- err_count  output  8  saturating timeout count
- iomem_valid  output  1  bus request
- iomem_ready  input  1  responder completion pulse
- iomem_wstrb  output  4  bus strobes
- iomem_addr  output  32  bus address
- iomem_wdata  output  32  bus write data
- iomem_rdata  input  32  bus read data, valid when iomem_ready=1

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on port reset.
- States: IDLE, BUS, RESP.
- Reset values:
  - State is IDLE.
  - cmd_ready=1 (registered, mirrors IDLE).
  - iomem_valid=0, rsp_valid=0, rsp_err=0.
  - rsp_rdata=0, err_count=0.
  - iomem_wstrb/addr/wdata=0.
  - Timeout counter 0.
- IDLE: on cmd_valid && cmd_ready at edge N:
  - Register strobes/addr/wdata onto the iomem_* outputs.
  - iomem_valid=1 and cmd_ready=0 from cycle N+1.
  - Clear counter; go to BUS.
- BUS:
  - iomem_valid, wstrb, addr and wdata are held stable until completion.
  - Counter increments each cycle.
  - Completion on an edge with iomem_ready=1:
    - iomem_valid=0 next cycle.
    - rsp_rdata <= iomem_rdata for reads, 0 for writes (wstrb != 0).
    - rsp_err=0, rsp_valid=1; go to RESP.
  - Minimum latency: command accepted at N, responder ready at N+1, rsp_valid at N+2.
  - Timeout (TIMEOUT_CYCLES != 0): on the edge where counter == TIMEOUT_CYCLES-1 and iomem_ready=0:
    - iomem_valid=0; rsp_rdata=ERR_RDATA; rsp_err=1; rsp_valid=1.
    - err_count += 1, saturating at 255; go to RESP.
  - iomem_ready and timeout on the same edge: ready wins, normal completion, no error.
- RESP:
  - rsp_valid and rsp_* are held until rsp_ready.
  - On the handshake: rsp_valid=0, cmd_ready=1 next cycle; go to IDLE.
  - Back-to-back: the next command is accepted at the earliest one cycle after the response handshake.
- Stray ready: iomem_ready seen in IDLE or RESP (e.g. a late ready after timeout) is ignored. No state, data or count change.
- iomem_valid never rises in the cycle immediately after it falls. Consecutive transactions therefore always have at least one low cycle between them, which is compatible with responders gating on valid && !ready.
- Reset mid-transaction: asserting reset in any state forces all outputs to reset values on the next edge. The pending response is discarded and err_count is cleared.
- cmd_* inputs are sampled only at acceptance; changes afterwards have no effect.

Test Plan:
- Write: cmd wstrb=4'hF, addr=32'h03000000, wdata=32'h000000A5; responder returns ready 2 cycles after valid -> iomem_valid high exactly 2 cycles with stable fields; rsp_valid, rsp_err=0, rsp_rdata=0.
- Read: cmd wstrb=0, addr=32'h03000000; responder returns rdata=32'h000000A5 with ready on the first valid cycle -> rsp_valid 2 cycles after acceptance, rsp_rdata=32'h000000A5.
- Timeout: TIMEOUT_CYCLES=8, responder never readies -> iomem_valid high exactly 8 cycles; rsp_err=1, rsp_rdata=32'hDEADBEEF, err_count=1; a late ready 3 cycles later is ignored.
- Race: ready asserted on cycle 8 with TIMEOUT_CYCLES=8 -> normal completion, rsp_err=0, err_count unchanged.
- Backpressure and back-to-back: hold rsp_ready=0 for 5 cycles, then issue 3 commands with cmd_valid held -> cmd_ready=0 throughout RESP; each valid pulse separated by at least one low cycle; responses in order.
- Reset mid-BUS: assert reset while iomem_valid=1 -> next cycle iomem_valid=0, cmd_ready=1, rsp_valid=0, err_count=0.
